// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU pipeline constants: default depth, stage indices and multi-cycle counter width.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned NUM_STAGES_DEF = 5;
  localparam int unsigned STG_IF         = 0;
  localparam int unsigned STG_ID         = 1;
  localparam int unsigned STG_EXE        = 2;
  localparam int unsigned STG_MEM        = 3;
  localparam int unsigned STG_WB         = 4;
  localparam int unsigned MC_CNT_W       = 6;

endpackage

// File: rtl/mc_stall_counter.sv
// Multi-cycle operation stall counter: load on start, decrement while busy, abort on flush.
module mc_stall_counter #(
  parameter int unsigned CNT_W = pipeline_hazard_ctrl_pkg::MC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_cycles,
  input  logic             abort,
  output logic             mc_active_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // The start cycle itself stalls, so the counter holds only the remaining cycles.
  always_comb begin
    cnt_nxt     = cnt;
    mc_active_c = (mc_start && (mc_cycles != '0)) || (cnt != '0);
    if (ena) begin
      if (abort) begin
        cnt_nxt = '0;
      end else if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else if (mc_start && (mc_cycles > CNT_W'(1))) begin
        cnt_nxt = mc_cycles - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable controller: valid bits, fill, stall/flush arbitration and PC/register enables.
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = pipeline_hazard_ctrl_pkg::NUM_STAGES_DEF,
  parameter int unsigned MC_STAGE   = pipeline_hazard_ctrl_pkg::STG_EXE,
  parameter int unsigned MC_CNT_W   = pipeline_hazard_ctrl_pkg::MC_CNT_W,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  mc_start,
  input  logic [MC_CNT_W-1:0]   mc_cycles,
  output logic                  pc_we,
  output logic [NUM_STAGES-2:0] reg_ena,
  output logic [NUM_STAGES-2:0] reg_clr,
  output logic [NUM_STAGES-2:0] reg_valid,
  output logic                  mc_busy,
  output logic [PERF_W-1:0]     perf_stall_cnt
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int unsigned NREG = NUM_STAGES - 1;

  // Oldest stalled stage; 0 when nothing stalls.
  function automatic int unsigned highest_stall(input logic [NUM_STAGES-1:0] s);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (s[i]) res = i;
    end
    return res;
  endfunction

  // Oldest flush strictly older than the stall point; 0 when none is honoured.
  function automatic int unsigned highest_flush(input logic [NUM_STAGES-1:0] fr,
                                                input int unsigned h_lim);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (fr[i] && (i > h_lim)) res = i;
    end
    return res;
  endfunction

  logic                  mc_active;
  logic                  mc_abort;
  logic [NUM_STAGES-1:0] stall_vec;
  logic [NREG-1:0]       upstream_valid;
  int unsigned           h;
  int unsigned           f;

  always_comb begin
    stall_vec           = stall_req;
    stall_vec[STG_IF]   = 1'b0;
    stall_vec[MC_STAGE] = stall_req[MC_STAGE] | mc_active;
    h                   = highest_stall(stall_vec);
    f                   = highest_flush(flush_req, h);
    mc_abort            = (f > MC_STAGE);
  end

  // Flush clear beats hold; the register just past the stall point takes a bubble.
  always_comb begin
    pc_we   = 1'b0;
    reg_ena = '0;
    reg_clr = '0;
    if (ena) begin
      pc_we = (h == 0) || (f > 0);
      for (int unsigned r = 0; r < NREG; r++) begin
        if (r < f) begin
          reg_ena[r] = 1'b1;
          reg_clr[r] = 1'b1;
        end else if (r < h) begin
          reg_ena[r] = 1'b0;
        end else if ((h != 0) && (r == h)) begin
          reg_ena[r] = 1'b1;
          reg_clr[r] = 1'b1;
        end else begin
          reg_ena[r] = 1'b1;
        end
      end
    end
  end

  assign mc_busy        = mc_active;
  assign upstream_valid = {reg_valid[NREG-2:0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_valid <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (reg_ena[r]) reg_valid[r] <= reg_clr[r] ? 1'b0 : upstream_valid[r];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
    end else if (ena && !pc_we && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end

  mc_stall_counter #(
    .CNT_W (MC_CNT_W)
  ) u_mc_stall_counter (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .mc_start    (mc_start),
    .mc_cycles   (mc_cycles),
    .abort       (mc_abort),
    .mc_active_c (mc_active)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized model comparison.
module tb_pipeline_hazard_ctrl;

  localparam int NS = 5;
  localparam int MC = 2;
  localparam int CW = 6;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ena;
  logic [NS-1:0] stall_req;
  logic [NS-1:0] flush_req;
  logic          mc_start;
  logic [CW-1:0] mc_cycles;
  logic          pc_we;
  logic [NS-2:0] reg_ena;
  logic [NS-2:0] reg_clr;
  logic [NS-2:0] reg_valid;
  logic          mc_busy;
  logic [PW-1:0] perf_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: live bits, remaining busy cycles, stall count.
  logic [NS-2:0] m_valid;
  int            m_rem;
  logic [PW-1:0] m_perf;
  logic [NS-2:0] e_ena, e_clr;
  logic          e_pc, e_busy;
  int            e_eff, e_f;
  logic [3:0]    fill_tab [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .NUM_STAGES (NS),
    .MC_STAGE   (MC),
    .MC_CNT_W   (CW),
    .PERF_W     (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ena            (ena),
    .stall_req      (stall_req),
    .flush_req      (flush_req),
    .mc_start       (mc_start),
    .mc_cycles      (mc_cycles),
    .pc_we          (pc_we),
    .reg_ena        (reg_ena),
    .reg_clr        (reg_clr),
    .reg_valid      (reg_valid),
    .mc_busy        (mc_busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic model_reset();
    m_valid = '0;
    m_rem   = 0;
    m_perf  = '0;
  endtask

  // Expected outputs this cycle, straight from the stall/flush rules.
  task automatic model_eval();
    int h, f;
    logic [NS-1:0] s;
    e_eff  = (m_rem == 0 && mc_start) ? int'(mc_cycles) : m_rem;
    e_busy = (e_eff > 0);
    s      = stall_req;
    s[0]   = 1'b0;
    if (e_busy) s[MC] = 1'b1;
    h = 0;
    for (int i = 1; i < NS; i++) if (s[i]) h = i;
    f = 0;
    for (int i = h + 1; i < NS; i++) if (flush_req[i]) f = i;
    e_f   = f;
    e_ena = '0;
    e_clr = '0;
    e_pc  = 1'b0;
    if (ena) begin
      e_pc = (h == 0) || (f > 0);
      for (int r = 0; r < NS - 1; r++) begin
        if (f > 0 && r <= f - 1) begin
          e_ena[r] = 1'b1; e_clr[r] = 1'b1;
        end else if (h > 0 && r <= h - 1) begin
          e_ena[r] = 1'b0;
        end else if (h > 0 && r == h) begin
          e_ena[r] = 1'b1; e_clr[r] = 1'b1;
        end else begin
          e_ena[r] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    logic [NS-2:0] nv;
    if (ena) begin
      nv = m_valid;
      for (int r = 0; r < NS - 1; r++) begin
        if (e_ena[r]) nv[r] = e_clr[r] ? 1'b0 : ((r == 0) ? 1'b1 : m_valid[r-1]);
      end
      m_valid = nv;
      if (!e_pc && m_perf != '1) m_perf = m_perf + 1;
      m_rem = (e_f > MC) ? 0 : ((e_eff > 0) ? e_eff - 1 : 0);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive_idle();
    ena = 1'b1; stall_req = '0; flush_req = '0; mc_start = 1'b0; mc_cycles = '0;
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    for (int k = 0; k < n; k++) begin
      settle();
      tick();
    end
  endtask

  task automatic test_reset();
    drive_idle();
    ena = 1'b0;
    settle();
    n_checks++; if (reg_valid !== 4'b0000) $display("FAIL reset_valid: got %b exp 0000", reg_valid); else n_pass++;
    n_checks++; if (perf_stall_cnt !== '0) $display("FAIL reset_perf: got %0d exp 0", perf_stall_cnt); else n_pass++;
    n_checks++; if (mc_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", mc_busy); else n_pass++;
    n_checks++; if (pc_we !== 1'b0) $display("FAIL reset_pc_we_ena0: got %b exp 0", pc_we); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      settle();
      n_checks++; if (reg_valid !== fill_tab[k]) $display("FAIL fill_valid[%0d]: got %b exp %b", k, reg_valid, fill_tab[k]); else n_pass++;
      n_checks++; if (pc_we !== 1'b1 || reg_ena !== 4'b1111) $display("FAIL fill_ena[%0d]: got pc_we=%b reg_ena=%b exp 1/1111", k, pc_we, reg_ena); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stall();
    drive_idle();
    stall_req = 5'b00100;
    settle();
    n_checks++; if (pc_we !== 1'b0) $display("FAIL stall_pc_we: got %b exp 0", pc_we); else n_pass++;
    n_checks++; if (reg_ena !== 4'b1100) $display("FAIL stall_reg_ena: got %b exp 1100", reg_ena); else n_pass++;
    n_checks++; if (reg_clr !== 4'b0100) $display("FAIL stall_reg_clr: got %b exp 0100", reg_clr); else n_pass++;
    tick();
    drive_idle();
    settle();
    n_checks++; if (reg_valid !== 4'b1011) $display("FAIL stall_valid: got %b exp 1011", reg_valid); else n_pass++;
    tick();
    idle_cycles(4);
  endtask

  task automatic test_mc();
    int busy_n = 0, pclow_n = 0;
    logic [PW-1:0] p0;
    p0 = m_perf;
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      mc_start  = (k < 3);
      mc_cycles = (k == 0) ? 6'd3 : 6'd7;
      settle();
      n_checks++; if (mc_busy !== (k < 3)) $display("FAIL mc_busy[%0d]: got %b exp %b", k, mc_busy, (k < 3)); else n_pass++;
      busy_n  += int'(mc_busy);
      pclow_n += int'(!pc_we);
      tick();
    end
    n_checks++; if (pclow_n != 3) $display("FAIL mc_pc_low_cycles: got %0d exp 3", pclow_n); else n_pass++;
    n_checks++; if (perf_stall_cnt !== p0 + 3) $display("FAIL mc_perf: got %0d exp %0d", perf_stall_cnt, p0 + 3); else n_pass++;
    idle_cycles(4);
  endtask

  task automatic test_flush();
    drive_idle();
    flush_req = 5'b01000;
    settle();
    n_checks++; if (reg_ena !== 4'b1111 || reg_clr !== 4'b0111 || pc_we !== 1'b1)
      $display("FAIL flush_enables: got ena=%b clr=%b pc=%b exp 1111/0111/1", reg_ena, reg_clr, pc_we); else n_pass++;
    tick();
    drive_idle();
    settle();
    n_checks++; if (reg_valid !== 4'b1000) $display("FAIL flush_valid: got %b exp 1000", reg_valid); else n_pass++;
    tick();
    flush_req = 5'b01000;
    stall_req = 5'b10000;
    settle();
    n_checks++; if (reg_ena !== 4'b0000 || reg_clr !== 4'b0000 || pc_we !== 1'b0)
      $display("FAIL flush_ignored: got ena=%b clr=%b pc=%b exp 0000/0000/0", reg_ena, reg_clr, pc_we); else n_pass++;
    tick();
    idle_cycles(4);
  endtask

  task automatic test_ena_freeze();
    logic [NS-2:0] v0;
    logic [PW-1:0] p0;
    int busy_n = 0;
    drive_idle();
    mc_start = 1'b1; mc_cycles = 6'd5;
    settle();
    tick();
    idle_cycles(1);
    v0 = m_valid;
    p0 = m_perf;
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if (mc_busy !== 1'b1 || pc_we !== 1'b0 || reg_ena !== 4'b0000)
        $display("FAIL freeze_out[%0d]: got busy=%b pc=%b ena=%b exp 1/0/0000", k, mc_busy, pc_we, reg_ena); else n_pass++;
      n_checks++; if (reg_valid !== v0 || perf_stall_cnt !== p0)
        $display("FAIL freeze_state[%0d]: got valid=%b perf=%0d exp %b/%0d", k, reg_valid, perf_stall_cnt, v0, p0); else n_pass++;
      tick();
    end
    ena = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      busy_n += int'(mc_busy);
      tick();
    end
    n_checks++; if (busy_n != 3) $display("FAIL freeze_resume_busy: got %0d exp 3", busy_n); else n_pass++;
    idle_cycles(4);
  endtask

  task automatic test_mc_abort();
    drive_idle();
    mc_start = 1'b1; mc_cycles = 6'd5;
    settle();
    tick();
    mc_start = 1'b0;
    settle();
    tick();
    flush_req = 5'b01000;
    settle();
    n_checks++; if (mc_busy !== 1'b1 || pc_we !== 1'b1) $display("FAIL abort_cycle: got busy=%b pc=%b exp 1/1", mc_busy, pc_we); else n_pass++;
    tick();
    flush_req = '0;
    settle();
    n_checks++; if (mc_busy !== 1'b0) $display("FAIL abort_busy_cleared: got %b exp 0", mc_busy); else n_pass++;
    tick();
    idle_cycles(4);
  endtask

  task automatic test_async_reset();
    drive_idle();
    mc_start = 1'b1; mc_cycles = 6'd8;
    settle();
    tick();
    mc_start = 1'b0;
    settle();
    tick();
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (reg_valid !== 4'b0000 || perf_stall_cnt !== '0 || mc_busy !== 1'b0)
      $display("FAIL async_reset: got valid=%b perf=%0d busy=%b exp 0000/0/0", reg_valid, perf_stall_cnt, mc_busy); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    model_eval();
    tick();
    settle();
    n_checks++; if (reg_valid !== 4'b0001) $display("FAIL reset_refill: got %b exp 0001", reg_valid); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ena       = ($urandom % 10) != 0;
      stall_req = (($urandom % 4) == 0) ? NS'($urandom) : '0;
      flush_req = (($urandom % 5) == 0) ? NS'($urandom) : '0;
      mc_start  = ($urandom % 8) == 0;
      mc_cycles = CW'($urandom_range(0, 9));
      settle();
      n_checks++; if (pc_we !== e_pc) $display("FAIL rand_pc_we c%0d: got %b exp %b", c, pc_we, e_pc); else n_pass++;
      n_checks++; if (reg_ena !== e_ena) $display("FAIL rand_reg_ena c%0d: got %b exp %b", c, reg_ena, e_ena); else n_pass++;
      n_checks++; if ((reg_clr & reg_ena) !== (e_clr & e_ena)) $display("FAIL rand_reg_clr c%0d: got %b exp %b", c, reg_clr & reg_ena, e_clr & e_ena); else n_pass++;
      n_checks++; if (reg_valid !== m_valid) $display("FAIL rand_valid c%0d: got %b exp %b", c, reg_valid, m_valid); else n_pass++;
      n_checks++; if (mc_busy !== e_busy) $display("FAIL rand_busy c%0d: got %b exp %b", c, mc_busy, e_busy); else n_pass++;
      n_checks++; if (perf_stall_cnt !== m_perf) $display("FAIL rand_perf c%0d: got %0d exp %0d", c, perf_stall_cnt, m_perf); else n_pass++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive_idle();
    ena = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_stall();
    test_mc();
    test_flush();
    test_ena_freeze();
    test_mc_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
